// File: rtl/wb_clint_pkg.sv
// -----------------------------------------------------------------------------
// wb_clint_pkg
// Shared definitions for the Wishbone CLINT-style timer block:
//   - byte offsets of the registers inside the decoded window
//   - reset value of mtimecmp
//   - byte_merge(): applies a byte-lane select to a 32-bit register word
// -----------------------------------------------------------------------------
package wb_clint_pkg;

    localparam logic [31:0] MSIP_OFF        = 32'h0000_0000;
    localparam logic [31:0] CTRL_OFF        = 32'h0000_0004;
    localparam logic [31:0] MTIMECMP_LO_OFF = 32'h0000_0008;
    localparam logic [31:0] MTIMECMP_HI_OFF = 32'h0000_000C;
    localparam logic [31:0] MTIME_LO_OFF    = 32'h0000_0010;
    localparam logic [31:0] MTIME_HI_OFF    = 32'h0000_0014;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace the selected byte lanes of old_word with those of new_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_clint_timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the clock for the mtime counter. count runs 0..div and then
// restarts; tick is high in the cycle where count == div, so div=0 ticks
// every cycle and div=N ticks every N+1 cycles.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   div    divider setting
//   clr    restart the count from 0 at this edge (ctrl or mtime written)
//   tick   advance mtime at this edge (combinational from count/div)
// -----------------------------------------------------------------------------
module timer_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    output logic             tick
);

    logic [DIV_W-1:0] count_r;

    assign tick = (count_r == div);

    // Prescale counter: wraps on tick, restarts on clr.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= '0;
        end else if (clr || tick) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/wb_clint_timer.sv
// -----------------------------------------------------------------------------
// wb_clint_timer
// Wishbone B4 pipelined responder with a CLINT-style machine timer.
// Registers (byte offset within a 2^ADDR_W window, aliased above):
//   0x00 msip[0]   0x04 ctrl div   0x08/0x0C mtimecmp lo/hi
//   0x10/0x14 mtime lo/hi          other offsets read 0, writes ignored
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i     request qualifiers (accept = cyc & stb)
//   wb_stall_o             always 0
//   wb_ack_o               one cycle after accept, masked by cyc
//   wb_we_i, wb_sel_i      write enable, byte lanes
//   wb_adr_i, wb_dat_i     byte address, write data
//   wb_dat_o               registered read data
//   timer_irq_o            mtime >= mtimecmp (registered)
//   soft_irq_o             msip (registered)
// -----------------------------------------------------------------------------
module wb_clint_timer
    import wb_clint_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DIV_W  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        timer_irq_o,
    output logic        soft_irq_o
);

    logic             msip_r;
    logic [DIV_W-1:0] div_r;
    logic [63:0]      mtimecmp_r;
    logic [63:0]      mtime_r;
    logic             ack_r;
    logic [31:0]      dat_r;
    logic             timer_irq_r;
    logic             soft_irq_r;

    logic             accept_s;
    logic             wr_s;
    logic [31:0]      off_s;
    logic [31:0]      rd_data_s;
    logic [31:0]      wr_word_s;
    logic             wr_msip_s;
    logic             wr_ctrl_s;
    logic             wr_cmp_lo_s;
    logic             wr_cmp_hi_s;
    logic             wr_mtime_lo_s;
    logic             wr_mtime_hi_s;
    logic             clr_s;
    logic             tick_s;
    logic [63:0]      mtime_nxt_s;
    logic             unused_s;

    assign accept_s = wb_cyc_i & wb_stb_i;
    // sel=0 is acked but has no side effects at all (no count restart either).
    assign wr_s     = accept_s & wb_we_i & (|wb_sel_i);
    // Word offset only; adr[1:0] and bits above the window are ignored.
    assign off_s    = {{(32-ADDR_W){1'b0}}, wb_adr_i[ADDR_W-1:2], 2'b00};
    assign unused_s = ^{wb_adr_i[31:ADDR_W], wb_adr_i[1:0]};

    // Read mux and write decode for the addressed register.
    always_comb begin
        rd_data_s     = 32'h0000_0000;
        wr_msip_s     = 1'b0;
        wr_ctrl_s     = 1'b0;
        wr_cmp_lo_s   = 1'b0;
        wr_cmp_hi_s   = 1'b0;
        wr_mtime_lo_s = 1'b0;
        wr_mtime_hi_s = 1'b0;
        case (off_s)
            MSIP_OFF: begin
                rd_data_s = {31'h0000_0000, msip_r};
                wr_msip_s = wr_s;
            end
            CTRL_OFF: begin
                rd_data_s = {{(32-DIV_W){1'b0}}, div_r};
                wr_ctrl_s = wr_s;
            end
            MTIMECMP_LO_OFF: begin
                rd_data_s   = mtimecmp_r[31:0];
                wr_cmp_lo_s = wr_s;
            end
            MTIMECMP_HI_OFF: begin
                rd_data_s   = mtimecmp_r[63:32];
                wr_cmp_hi_s = wr_s;
            end
            MTIME_LO_OFF: begin
                rd_data_s     = mtime_r[31:0];
                wr_mtime_lo_s = wr_s;
            end
            MTIME_HI_OFF: begin
                rd_data_s     = mtime_r[63:32];
                wr_mtime_hi_s = wr_s;
            end
            default: begin
                rd_data_s = 32'h0000_0000;
            end
        endcase
    end

    // The merge base is the current value of the addressed register.
    assign wr_word_s = byte_merge(rd_data_s, wb_dat_i, wb_sel_i);
    assign clr_s     = wr_ctrl_s | wr_mtime_lo_s | wr_mtime_hi_s;

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .div   (div_r),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Next mtime: a bus write to either half wins over a tick on the same edge.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (wr_mtime_lo_s) begin
            mtime_nxt_s = {mtime_r[63:32], wr_word_s};
        end else if (wr_mtime_hi_s) begin
            mtime_nxt_s = {wr_word_s, mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Register state, bus response and interrupt outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            msip_r      <= 1'b0;
            div_r       <= '0;
            mtimecmp_r  <= MTIMECMP_RST;
            mtime_r     <= 64'd0;
            ack_r       <= 1'b0;
            dat_r       <= 32'h0000_0000;
            timer_irq_r <= 1'b0;
            soft_irq_r  <= 1'b0;
        end else begin
            ack_r <= accept_s;
            // Read data is the pre-update value, also for writes.
            if (accept_s) begin
                dat_r <= rd_data_s;
            end
            if (wr_msip_s) begin
                msip_r <= wr_word_s[0];
            end
            if (wr_ctrl_s) begin
                div_r <= wr_word_s[DIV_W-1:0];
            end
            if (wr_cmp_lo_s) begin
                mtimecmp_r[31:0] <= wr_word_s;
            end
            if (wr_cmp_hi_s) begin
                mtimecmp_r[63:32] <= wr_word_s;
            end
            mtime_r     <= mtime_nxt_s;
            timer_irq_r <= (mtime_r >= mtimecmp_r);
            soft_irq_r  <= msip_r;
        end
    end

    // An ack pending when reset is raised is never shown on the bus.
    assign wb_ack_o    = ack_r & wb_cyc_i & ~rst_i;
    assign wb_stall_o  = 1'b0;
    assign wb_dat_o    = dat_r;
    assign timer_irq_o = timer_irq_r;
    assign soft_irq_o  = soft_irq_r;

endmodule
